// File: rtl/sys_defs.sv
// Shared predictor types: fetch-slot result, BTB entry and resolved-branch update packet.
package sys_defs;

    localparam int ADDR_W      = 32;
    localparam int BP_TAG_BITS = 8;

    typedef logic [ADDR_W-1:0] ADDR;

    // Weak not-taken: one taken resolution flips the prediction.
    localparam logic [1:0] BP_CTR_WNT = 2'b01;

    typedef struct packed {
        logic valid;
        logic taken;
        ADDR  pc;
    } PC_ENTRY;

    typedef struct packed {
        logic                   valid;
        logic [BP_TAG_BITS-1:0] tag;
        ADDR                    target;
    } BTB_ENTRY;

    typedef struct packed {
        logic valid;
        ADDR  pc;
        logic taken;
        ADDR  target;
    } BP_UPDATE_PACKET;

endpackage

// File: rtl/bp_pht.sv
// Table of 2-bit saturating direction counters: WIDTH combinational read ports and
// UPD_PORTS update ports applied in ascending order within one cycle.
module bp_pht
    import sys_defs::*;
#(
    parameter int PHT_SIZE  = 64,
    parameter int WIDTH     = 3,
    parameter int UPD_PORTS = 2,
    localparam int IDX_W    = $clog2(PHT_SIZE)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [WIDTH-1:0][IDX_W-1:0]     rd_idx,
    output logic [WIDTH-1:0][1:0]           rd_ctr,
    input  logic [UPD_PORTS-1:0]            upd_valid,
    input  logic [UPD_PORTS-1:0][IDX_W-1:0] upd_idx,
    input  logic [UPD_PORTS-1:0]            upd_taken
);

    logic [1:0] ctr      [PHT_SIZE];
    logic [1:0] ctr_next [PHT_SIZE];

    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
        if (up)
            return (c == 2'b11) ? c : 2'(c + 2'd1);
        else
            return (c == 2'b00) ? c : 2'(c - 2'd1);
    endfunction

    always_comb begin
        for (int i = 0; i < WIDTH; i++)
            rd_ctr[i] = ctr[rd_idx[i]];
    end

    // Chaining through ctr_next lets two hits on one counter in a cycle both count.
    always_comb begin
        ctr_next = ctr;
        for (int p = 0; p < UPD_PORTS; p++) begin
            if (upd_valid[p])
                ctr_next[upd_idx[p]] = sat_step(ctr_next[upd_idx[p]], upd_taken[p]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            ctr <= '{default: BP_CTR_WNT};
        else
            ctr <= ctr_next;
    end

endmodule

// File: rtl/bp_btb_bimodal.sv
// N-wide next-PC predictor: direct-mapped BTB plus a bp_pht counter table.
// Define BP_GSHARE_EN to hash the PHT index with resolve-time global history.
module bp_btb_bimodal
    import sys_defs::*;
#(
    parameter int WIDTH     = 3,
    parameter int UPD_PORTS = 2,
    parameter int BTB_SETS  = 16,
    parameter int PHT_SIZE  = 64,
    parameter int GHR_BITS  = 6
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [ADDR_W-1:0]                 pc_start,
    input  logic [UPD_PORTS-1:0]              upd_valid,
    input  logic [UPD_PORTS-1:0][ADDR_W-1:0]  upd_pc,
    input  logic [UPD_PORTS-1:0]              upd_taken,
    input  logic [UPD_PORTS-1:0][ADDR_W-1:0]  upd_target,
    output PC_ENTRY [WIDTH-1:0]               target_pc
);

    // Tag width is fixed by the shared BTB_ENTRY layout.
    localparam int TAG_BITS  = BP_TAG_BITS;
    localparam int BTB_IDX_W = $clog2(BTB_SETS);
    localparam int PHT_IDX_W = $clog2(PHT_SIZE);

    function automatic logic [BTB_IDX_W-1:0] btb_index(input ADDR a);
        return a[2 +: BTB_IDX_W];
    endfunction

    function automatic logic [TAG_BITS-1:0] btb_tag(input ADDR a);
        return a[2 + BTB_IDX_W +: TAG_BITS];
    endfunction

    logic [PHT_IDX_W-1:0] hist_mix;

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr;
    logic [GHR_BITS-1:0] ghr_next;

    always_comb begin
        ghr_next = ghr;
        for (int p = 0; p < UPD_PORTS; p++) begin
            if (upd_valid[p])
                ghr_next = {ghr_next[GHR_BITS-2:0], upd_taken[p]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            ghr <= '0;
        else
            ghr <= ghr_next;
    end

    // Reads and updates both hash with the history as it stood before the edge.
    assign hist_mix = PHT_IDX_W'(ghr);
`else
    assign hist_mix = '0;
`endif

    function automatic logic [PHT_IDX_W-1:0] pht_index(input ADDR a, input logic [PHT_IDX_W-1:0] h);
        return a[2 +: PHT_IDX_W] ^ h;
    endfunction

    BP_UPDATE_PACKET upd [UPD_PORTS];

    always_comb begin
        for (int p = 0; p < UPD_PORTS; p++) begin
            upd[p].valid  = upd_valid[p];
            upd[p].pc     = upd_pc[p];
            upd[p].taken  = upd_taken[p];
            upd[p].target = upd_target[p];
        end
    end

    logic [BTB_SETS-1:0] btb_valid;
    logic [TAG_BITS-1:0] btb_tag_mem [BTB_SETS];
    ADDR                 btb_tgt_mem [BTB_SETS];

    // Later ports overwrite earlier ones, so the highest index wins a set collision.
    always_ff @(posedge clock) begin
        if (reset) begin
            btb_valid <= '0;
        end else begin
            for (int p = 0; p < UPD_PORTS; p++) begin
                if (upd[p].valid && upd[p].taken)
                    btb_valid[btb_index(upd[p].pc)] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int p = 0; p < UPD_PORTS; p++) begin
            if (upd[p].valid && upd[p].taken) begin
                btb_tag_mem[btb_index(upd[p].pc)] <= btb_tag(upd[p].pc);
                btb_tgt_mem[btb_index(upd[p].pc)] <= upd[p].target;
            end
        end
    end

    logic [UPD_PORTS-1:0][PHT_IDX_W-1:0] pht_upd_idx;
    logic [WIDTH-1:0][PHT_IDX_W-1:0]     pht_rd_idx;
    logic [WIDTH-1:0][1:0]               pht_rd_ctr;

    always_comb begin
        for (int p = 0; p < UPD_PORTS; p++)
            pht_upd_idx[p] = pht_index(upd[p].pc, hist_mix);
    end

    bp_pht #(
        .PHT_SIZE  (PHT_SIZE),
        .WIDTH     (WIDTH),
        .UPD_PORTS (UPD_PORTS)
    ) u_pht (
        .clock     (clock),
        .reset     (reset),
        .rd_idx    (pht_rd_idx),
        .rd_ctr    (pht_rd_ctr),
        .upd_valid (upd_valid),
        .upd_idx   (pht_upd_idx),
        .upd_taken (upd_taken)
    );

    ADDR        spc_base;
    ADDR        spc      [WIDTH];
    BTB_ENTRY   rd_entry [WIDTH];
    logic [WIDTH-1:0] slot_taken;

    assign spc_base = pc_start & ~ADDR'(3);

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            spc[i]             = spc_base + ADDR'(4 * i);
            pht_rd_idx[i]      = pht_index(spc[i], hist_mix);
            rd_entry[i].valid  = btb_valid[btb_index(spc[i])];
            rd_entry[i].tag    = btb_tag_mem[btb_index(spc[i])];
            rd_entry[i].target = btb_tgt_mem[btb_index(spc[i])];
            slot_taken[i]      = rd_entry[i].valid && (rd_entry[i].tag == btb_tag(spc[i]))
                                 && pht_rd_ctr[i][1];
        end
    end

    // Slots behind the first predicted-taken slot are squashed and carry its target.
    logic redirect_seen;
    ADDR  redirect_pc;

    always_comb begin
        redirect_seen = 1'b0;
        redirect_pc   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (redirect_seen) begin
                target_pc[i] = '{valid: 1'b0, taken: 1'b0, pc: redirect_pc};
            end else if (slot_taken[i]) begin
                target_pc[i]  = '{valid: 1'b1, taken: 1'b1, pc: rd_entry[i].target};
                redirect_seen = 1'b1;
                redirect_pc   = rd_entry[i].target;
            end else begin
                target_pc[i] = '{valid: 1'b1, taken: 1'b0, pc: spc[i] + ADDR'(4)};
            end
        end
    end

endmodule
